sr4094_chain_writer: RTL

//   Serialises a parallel control word into the daisy-chained 4094 shift registers (GLB_4094_DATA/CLK) and pulses one strobe.

---
 rtl/sr4094_chain_writer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sr4094_chain_writer.sv
// rtl/sr4094_chain_writer.sv - serialises a parallel word into a 4094 daisy chain and issues one strobe
// Optional SR4094_READBACK_EN: capture the chain's previous contents from miso while shifting.
module sr4094_chain_writer #(
    parameter int NBYTES     = 2,
    parameter int CLK_DIV    = 4,
    parameter int STROBE_LEN = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   data,
    input  logic                  oe_en,
    input  logic                  miso,
    output logic                  busy,
    output logic                  done,
    output logic                  sr_clk,
    output logic                  sr_data,
    output logic                  sr_strobe,
    output logic                  sr_oe,
    output logic [8*NBYTES-1:0]   readback
);
    localparam int NBITS   = 8 * NBYTES;
    localparam int CNT_MAX = (CLK_DIV > STROBE_LEN) ? CLK_DIV : STROBE_LEN;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(NBITS + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STROBE_LEN - 1);
    localparam logic [BW-1:0] BITS_ALL = BW'(NBITS);

    typedef enum logic [1:0] {IDLE, SHIFT, STROBE} state_t;

    state_t           state;
    logic [NBITS-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    bit_cnt;
    logic             clk_rise;
    logic             strobe_end;

    assign clk_rise   = (state == SHIFT) && !sr_clk && (cnt == DIV_LAST);
    assign strobe_end = (state == STROBE) && (cnt == STB_LAST);

    // shreg holds the bits still to be sent; the bit on sr_data is already removed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sr_clk    <= 1'b0;
            sr_data   <= 1'b0;
            sr_strobe <= 1'b0;
            shreg     <= '0;
            cnt       <= '0;
            bit_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= {data[NBITS-2:0], 1'b0};
                        sr_data <= data[NBITS-1];
                        busy    <= 1'b1;
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (!sr_clk) begin
                            sr_clk  <= 1'b1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end else begin
                            sr_clk <= 1'b0;
                            if (bit_cnt == BITS_ALL) begin
                                sr_strobe <= 1'b1;
                                state     <= STROBE;
                            end else begin
                                sr_data <= shreg[NBITS-1];
                                shreg   <= {shreg[NBITS-2:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STROBE: begin
                    if (strobe_end) begin
                        sr_strobe <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_oe <= 1'b0;
        else        sr_oe <= oe_en;
    end

`ifdef SR4094_READBACK_EN
    logic [NBITS-1:0] capture;

    // miso is sampled before the chain shifts, so the old far-end bit lands first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            capture  <= '0;
            readback <= '0;
        end else begin
            if (clk_rise)   capture  <= {capture[NBITS-2:0], miso};
            if (strobe_end) readback <= capture;
        end
    end
`else
    logic unused_miso;
    assign unused_miso = miso;
    assign readback    = '0;
`endif

endmodule
